game_ctrl: RTL and testbench

Turn controller for the dice-to-fifteen game; the initiator side of the roll/choose handshake. It samples a free-running die on a player roll and issues a one-cycle start pulse carrying the rolled number and current score to the choice block. It then waits for that block's done pulse and commits the returned result and score. It owns the authoritative score register and the game status that drives the display.

---
 rtl/game_pkg.sv | 26 ++
 rtl/dice_counter.sv | 22 ++
 rtl/game_ctrl.sv | 133 +++++++++++++
 tb/tb_game_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared encodings for the dice-to-fifteen game (controller and choice block)
package game_pkg;

  localparam logic [1:0] RES_CONTINUE = 2'b00;
  localparam logic [1:0] RES_LOST     = 2'b01;
  localparam logic [1:0] RES_WON      = 2'b10;

  localparam logic [1:0] STAT_PLAYING = 2'b00;
  localparam logic [1:0] STAT_LOST    = 2'b01;
  localparam logic [1:0] STAT_WON     = 2'b10;

  localparam logic [3:0] MAX_SCORE = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RESP,
    ST_WON,
    ST_LOST
  } state_t;

  function automatic logic [2:0] next_face(input logic [2:0] face);
    return (face == 3'd6) ? 3'd1 : face + 3'd1;
  endfunction

endpackage

// File: rtl/dice_counter.sv
// rtl/dice_counter.sv - free-running die face counter cycling 1..6
module dice_counter
  import game_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [2:0] o_face
);

  logic [2:0] r_face;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_face <= 3'd1;
    end else begin
      r_face <= next_face(r_face);
    end
  end

  assign o_face = r_face;

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - turn controller: roll/choose handshake initiator, score and status owner
// Optional turn limit enabled by defining GAME_CTRL_TURN_LIMIT_EN.
module game_ctrl
  import game_pkg::*;
#(
  parameter int TURN_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll,
  input  logic       restart,
  input  logic       choose_done,
  input  logic [1:0] choose_result,
  input  logic [3:0] choose_score,
  output logic       choose_start,
  output logic [2:0] num,
  output logic [3:0] score,
  output logic [1:0] status,
  output logic       busy
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] w_face;
  logic [2:0] r_num;
  logic [3:0] r_score;
  logic [3:0] w_score_nxt;
  logic       r_roll_d;
  logic       w_roll_edge;
  logic       w_resp_take;
  logic       w_limit_hit;

  dice_counter u_dice (
    .i_clk  (clk),
    .i_rst  (rst),
    .o_face (w_face)
  );

  // r_roll_d resets high so a button held through reset is not an edge
  assign w_roll_edge = roll & ~r_roll_d;
  assign w_resp_take = (r_state == ST_WAIT_RESP) & choose_done;

`ifdef GAME_CTRL_TURN_LIMIT_EN
  localparam logic [3:0] LIMIT = 4'(TURN_LIMIT);
  logic [3:0] r_turns;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_turns <= 4'd0;
    end else if (w_resp_take) begin
      r_turns <= r_turns + 4'd1;
    end
  end

  assign w_limit_hit = ((r_turns + 4'd1) == LIMIT);
`else
  assign w_limit_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_score_nxt = r_score;
    case (r_state)
      ST_IDLE: begin
        if (w_roll_edge) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (choose_done) begin
          case (choose_result)
            RES_WON: begin
              w_state_nxt = ST_WON;
              w_score_nxt = MAX_SCORE;
            end
            // choose_score may be a truncated 16 here, so it is not used
            RES_LOST: begin
              w_state_nxt = ST_LOST;
              w_score_nxt = 4'd0;
            end
            default: begin
              w_state_nxt = ST_IDLE;
              if (choose_result == RES_CONTINUE) w_score_nxt = choose_score;
              if (w_limit_hit) begin
                w_state_nxt = ST_LOST;
                w_score_nxt = 4'd0;
              end
            end
          endcase
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_num    <= 3'd1;
      r_score  <= 4'd0;
      r_roll_d <= 1'b1;
    end else begin
      r_roll_d <= roll;
      if (restart) begin
        r_state <= ST_IDLE;
        r_num   <= 3'd1;
        r_score <= 4'd0;
      end else begin
        r_state <= w_state_nxt;
        r_score <= w_score_nxt;
        if ((r_state == ST_IDLE) && w_roll_edge) r_num <= w_face;
      end
    end
  end

  always_comb begin
    status = STAT_PLAYING;
    case (r_state)
      ST_WON:  status = STAT_WON;
      ST_LOST: status = STAT_LOST;
      default: status = STAT_PLAYING;
    endcase
  end

  assign choose_start = (r_state == ST_ISSUE);
  assign busy         = (r_state == ST_ISSUE) || (r_state == ST_WAIT_RESP);
  assign num          = r_num;
  assign score        = r_score;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl
module tb_game_ctrl;

`ifdef GAME_CTRL_TURN_LIMIT_EN
  localparam int TL = 3;
`else
  localparam int TL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       roll;
  logic       restart;
  logic       choose_done;
  logic [1:0] choose_result;
  logic [3:0] choose_score;
  logic       choose_start;
  logic [2:0] num;
  logic [3:0] score;
  logic [1:0] status;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int die_m    = 1;
  int starts;

  game_ctrl #(.TURN_LIMIT(TL)) dut (
    .clk           (clk),
    .rst           (rst),
    .roll          (roll),
    .restart       (restart),
    .choose_done   (choose_done),
    .choose_result (choose_result),
    .choose_score  (choose_score),
    .choose_start  (choose_start),
    .num           (num),
    .score         (score),
    .status        (status),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) die_m <= 1;
    else     die_m <= (die_m == 6) ? 1 : die_m + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_turn(input logic [1:0] res, input logic [3:0] sc);
    roll = 1'b1;
    tick();
    chk("turn_start", choose_start, 1'b1);
    roll = 1'b0;
    tick();
    chk("turn_wait_busy", busy, 1'b1);
    choose_done   = 1'b1;
    choose_result = res;
    choose_score  = sc;
    tick();
    choose_done = 1'b0;
    chk("turn_done_busy", busy, 1'b0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    rst = 1'b1; roll = 1'b0; restart = 1'b0;
    choose_done = 1'b0; choose_result = 2'b00; choose_score = 4'd0;
    tick(); tick();
    chk("rst_start", choose_start, 1'b0);
    chk("rst_num", num, 3'd1);
    chk("rst_score", score, 4'd0);
    chk("rst_status", status, 2'b00);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      if (die_m == 4) break;
      tick();
    end
    chk("die_reach_4", die_m, 4);
    roll = 1'b1;
    tick();
    chk("t1_start", choose_start, 1'b1);
    chk("t1_num", num, 3'd4);
    chk("t1_busy_issue", busy, 1'b1);
    roll = 1'b0;
    tick();
    chk("t1_start_one_cycle", choose_start, 1'b0);
    chk("t1_busy_wait", busy, 1'b1);
    choose_done = 1'b1; choose_result = 2'b00; choose_score = 4'd4;
    tick();
    choose_done = 1'b0;
    chk("t1_score", score, 4'd4);
    chk("t1_status", status, 2'b00);
    chk("t1_busy", busy, 1'b0);
    chk("t1_num_stable", num, 3'd4);

    do_turn(2'b00, 4'd9);
    chk("t2_score", score, 4'd9);
    do_turn(2'b10, 4'd15);
    chk("won_score", score, 4'd15);
    chk("won_status", status, 2'b10);
    starts = 0;
    roll = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (choose_start) starts++;
    end
    roll = 1'b0;
    chk("won_roll_ignored", starts, 0);
    choose_done = 1'b1; choose_result = 2'b01; choose_score = 4'd3;
    tick();
    choose_done = 1'b0;
    chk("won_done_ignored", status, 2'b10);

    do_restart();
    chk("rs1_score", score, 4'd0);
    chk("rs1_status", status, 2'b00);
    chk("rs1_num", num, 3'd1);
    do_turn(2'b00, 4'd5);
    chk("t4_score", score, 4'd5);
    do_turn(2'b01, 4'd0);
    chk("lost_score", score, 4'd0);
    chk("lost_status", status, 2'b01);

    do_restart();
    starts = 0;
    roll = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (choose_start) starts++;
    end
    roll = 1'b0;
    chk("held_roll_one_start", starts, 1);
    chk("held_roll_waiting", busy, 1'b1);
    choose_done = 1'b1; choose_result = 2'b00; choose_score = 4'd2;
    tick();
    choose_done = 1'b0;
    chk("held_score", score, 4'd2);
    choose_done = 1'b1; choose_result = 2'b10; choose_score = 4'd15;
    tick();
    choose_done = 1'b0;
    tick();
    chk("idle_done_score", score, 4'd2);
    chk("idle_done_status", status, 2'b00);
    chk("idle_done_busy", busy, 1'b0);

    roll = 1'b1;
    tick();
    roll = 1'b0;
    tick();
    chk("rw_in_wait", busy, 1'b1);
    restart = 1'b1;
    choose_done = 1'b1; choose_result = 2'b10; choose_score = 4'd15;
    tick();
    restart = 1'b0; choose_done = 1'b0;
    chk("rw_status", status, 2'b00);
    chk("rw_score", score, 4'd0);
    chk("rw_busy", busy, 1'b0);
    chk("rw_num", num, 3'd1);
    tick();
    chk("rw_no_start", choose_start, 1'b0);

    do_turn(2'b00, 4'd6);
    chk("pre_ill_score", score, 4'd6);
    do_turn(2'b11, 4'd9);
    chk("ill_score", score, 4'd6);
    chk("ill_status", status, 2'b00);

`ifdef GAME_CTRL_TURN_LIMIT_EN
    do_restart();
    do_turn(2'b00, 4'd1);
    do_turn(2'b00, 4'd2);
    chk("lim_before_status", status, 2'b00);
    chk("lim_before_score", score, 4'd2);
    do_turn(2'b00, 4'd3);
    chk("lim_status", status, 2'b01);
    chk("lim_score", score, 4'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
